// File: rtl/riscv_data_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_mem_if
//  Description : Request/response channel bundle between the LSU (master)
//                and riscv_data_mem (slave).
//                Request channel  : req_valid/req_ready handshake carrying
//                                   req_we, req_funct3, req_addr, req_wdata.
//                Response channel : resp_valid/resp_ready handshake carrying
//                                   resp_rdata, resp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_data_mem_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_rdata;
   logic                  resp_err;

   // Requester side (core LSU)
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   // Memory side
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/riscv_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_data_mem
//  Description : Byte-addressable RV32 data memory, DEPTH_WORDS x 32 bits,
//                little-endian, one access outstanding. Supports B/H/W
//                stores and B/H/W/BU/HU loads with sign/zero extension.
//                Illegal funct3, misaligned and out-of-range accesses are
//                reported through resp_err and never touch the array.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - riscv_data_mem_if.slave (request + response channels)
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_data_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   riscv_data_mem_if.slave    bus
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   // One extra bit so the limit itself is representable and the comparison
   // uses every address bit (no aliasing of high addresses onto the array).
   localparam logic [ADDR_WIDTH:0] c_addr_limit =
      (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) << 2);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_resp = 1'b1;

   localparam logic [2:0] c_f3_b  = 3'b000;
   localparam logic [2:0] c_f3_h  = 3'b001;
   localparam logic [2:0] c_f3_w  = 3'b010;
   localparam logic [2:0] c_f3_bu = 3'b100;
   localparam logic [2:0] c_f3_hu = 3'b101;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]  state_q, state_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   // Not reset: contents survive reset and are undefined until written.
   logic [31:0] mem_q [DEPTH_WORDS];

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic               w_accept;
   logic               w_f3_illegal;
   logic               w_misaligned;
   logic               w_out_of_range;
   logic               w_err;
   logic               w_do_write;
   logic [c_idx_w-1:0] w_word_idx;
   logic [1:0]         w_lane;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata_rep;
   logic [31:0]        w_rd_word;
   logic [7:0]         w_rd_byte;
   logic [15:0]        w_rd_half;
   logic [31:0]        w_load_data;

   // rst_n gates acceptance so nothing is written while reset is held.
   assign w_accept   = bus.req_valid && rst_n && (state_q == c_st_idle);
   assign w_lane     = bus.req_addr[1:0];
   assign w_word_idx = bus.req_addr[c_idx_w+1:2];

   always_comb begin
      w_f3_illegal = 1'b0;
      case (bus.req_funct3)
         c_f3_b, c_f3_h, c_f3_w: w_f3_illegal = 1'b0;
         c_f3_bu, c_f3_hu:       w_f3_illegal = bus.req_we;  // load-only
         default:                w_f3_illegal = 1'b1;
      endcase

      w_misaligned = 1'b0;
      case (bus.req_funct3)
         c_f3_h, c_f3_hu: w_misaligned = bus.req_addr[0];
         c_f3_w:          w_misaligned = |bus.req_addr[1:0];
         default:         w_misaligned = 1'b0;
      endcase

      w_out_of_range = ({1'b0, bus.req_addr} >= c_addr_limit);

      w_err = w_f3_illegal | w_misaligned | w_out_of_range;
   end

   // Store byte enables and lane-replicated write data. Half stores are
   // known to be half-aligned when legal, so a lane shift of 0 or 2 suffices.
   always_comb begin
      w_be        = 4'b1111;
      w_wdata_rep = bus.req_wdata;
      case (bus.req_funct3[1:0])
         2'b00: begin
            w_be        = 4'b0001 << w_lane;
            w_wdata_rep = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = 4'b0011 << w_lane;
            w_wdata_rep = {2{bus.req_wdata[15:0]}};
         end
         default: begin
            w_be        = 4'b1111;
            w_wdata_rep = bus.req_wdata;
         end
      endcase
   end

   assign w_do_write = w_accept && bus.req_we && !w_err;

   // ------------------------------------------------------------------------
   // Memory array: byte-lane write at the accepting edge
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               mem_q[w_word_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Load alignment and extension
   // ------------------------------------------------------------------------
   assign w_rd_word = mem_q[w_word_idx];

   always_comb begin
      w_rd_byte   = w_rd_word[8*w_lane +: 8];
      w_rd_half   = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      w_load_data = 32'h0;
      case (bus.req_funct3)
         c_f3_b:  w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
         c_f3_h:  w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
         c_f3_w:  w_load_data = w_rd_word;
         c_f3_bu: w_load_data = {24'h0, w_rd_byte};
         c_f3_hu: w_load_data = {16'h0, w_rd_half};
         default: w_load_data = 32'h0;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= c_st_idle;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and response capture
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         c_st_idle: begin
            if (w_accept) begin
               state_d      = c_st_resp;
               resp_err_d   = w_err;
               // Stores and errors always return zero data.
               resp_rdata_d = (w_err || bus.req_we) ? 32'h0 : w_load_data;
            end
         end
         c_st_resp: begin
            // Response fields hold until the consumer takes them.
            if (bus.resp_ready) begin
               state_d = c_st_idle;
            end
         end
         default: state_d = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      bus.req_ready  = rst_n && (state_q == c_st_idle);
      bus.resp_valid = (state_q == c_st_resp);
      bus.resp_rdata = resp_rdata_q;
      bus.resp_err   = resp_err_q;
   end

endmodule
`default_nettype wire
